axis_to_dvp: RTL and testbench
==============================

AXIS_TO_DVP -- requirements
Module: axis_to_dvp

Interface
REQ-001 Parameter H_ACTIVE, default 640, pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, lines per frame.
REQ-003 Parameter H_BLANK, default 16, LV-low cycles between lines inside a frame (>=1).
REQ-004 Parameter V_PORCH, default 4, FV-high/LV-low cycles before the first line and after the last line (>=1).
REQ-005 Parameter V_BLANK, default 8, FV-low cycles after each frame (>=1).
REQ-006 The clock SHALL be pclk; there is one clock; reset is asynchronous and active-high.
REQ-007 Ports: pclk  in  1  pixel clock, sole clock.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 s_axis_tdata  in  16  pixel data; s_axis_tvalid  in  1; s_axis_tready  out  1.
REQ-010 s_axis_tuser  in  1  start of frame; s_axis_tlast  in  1  end of line.
REQ-011 FV  out  1  frame valid; LV  out  1  line valid; D_OUT  out  16  pixel data.
REQ-012 frame_done  out  1  one-cycle pulse; err_underflow  out  1  sticky; err_framing  out  1  sticky.

Function
REQ-013 States SHALL be WAIT_SOF, V_PRE, LINE, H_BLK, V_POST, V_BLK.
REQ-014 WAIT_SOF: s_axis_tready = NOT(tvalid AND tuser); beats with tuser=0 SHALL be consumed and discarded; tvalid AND tuser SHALL move the FSM to V_PRE without consuming that beat.
REQ-015 V_PRE: FV=1, LV=0 for V_PORCH cycles, then LINE.
REQ-016 LINE: exactly H_ACTIVE cycles; s_axis_tready=1 every cycle; LV=1.
REQ-017 Latency: a beat accepted at edge k SHALL appear on D_OUT with LV=1 in the cycle after k; FV, LV and D_OUT are registered.
REQ-018 Underflow: a LINE cycle with tvalid=0 SHALL still advance the pixel counter and output LV=1 with D_OUT=0, and SHALL set err_underflow. Line and frame timing SHALL never stretch.
REQ-019 After the last pixel: if line count = V_ACTIVE-1, go to V_POST; otherwise go to H_BLK.
REQ-020 H_BLK: FV=1, LV=0, D_OUT=0, tready=0 for H_BLANK cycles, then LINE.
REQ-021 V_POST: FV=1, LV=0 for V_PORCH cycles, then V_BLK; frame_done SHALL pulse in the first V_BLK cycle.
REQ-022 V_BLK: FV=0, tready=0 for V_BLANK cycles, then WAIT_SOF.
REQ-023 Framing check on each accepted LINE beat: set err_framing if tlast differs from (pixel = H_ACTIVE-1), or if tuser=1 on any beat other than line 0 pixel 0. Timing SHALL continue unchanged.
REQ-024 D_OUT SHALL be 0 whenever LV=0.
REQ-025 Counters SHALL be sized with $clog2 of their maximum value and SHALL wrap to 0 on state exit.
REQ-026 Error flags SHALL clear only on reset.

Reset
REQ-027 While reset=1: state is WAIT_SOF; FV, LV, D_OUT, s_axis_tready, frame_done, err_underflow and err_framing are all 0; all counters are 0.
REQ-028 Reset asserted mid-frame SHALL drop FV and LV immediately (asynchronously). After release, the block SHALL wait for a new tuser beat.

Structure
REQ-029 Package axis_dvp_pkg SHALL hold the state enum dvp_state_t and the constant DVP_DATA_W = 16.
REQ-030 Sub-module dvp_timing_gen SHALL hold the FSM and the pixel, line and blanking counters, and SHALL output the state, the pixel index and the line index. The top level SHALL hold the datapath, the handshake logic and the error logic.

Verification (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, V_PORCH=1, V_BLANK=3)
REQ-031 Two beats with tuser=0 (0x0001, 0x0002), then a continuous frame 0x0010..0x0017 starting with tuser=1 -> the two leading beats are dropped; FV is high for 1+4+2+4+1 = 12 cycles; LV shows 0x0010..0x0013, is low 2 cycles, then shows 0x0014..0x0017; frame_done pulses once; both error flags stay 0.
REQ-032 tvalid held low during line 1 pixel 2 -> that pixel is D_OUT=0 with LV=1; err_underflow=1; FV length unchanged at 12.
REQ-033 tlast=1 on line 0 pixel 1 -> err_framing=1; LV timing unchanged.
REQ-034 Reset pulsed during line 0 pixel 2 -> FV and LV are 0 in the same cycle; after release, beats with tuser=0 are discarded until the next tuser=1.
REQ-035 Two back-to-back frames -> exactly 3 FV-low cycles between them (plus WAIT_SOF cycles only if tuser is late); frame_done pulses twice.
REQ-036 Random tready checker: no beat is accepted during H_BLK, V_PRE, V_POST or V_BLK.

Source files
------------

// File: rtl/axis_dvp_pkg.sv
// Shared types and sizing helpers for the AXI-Stream to DVP (FV/LV) converter.
package axis_dvp_pkg;

  localparam int DVP_DATA_W = 16;

  typedef enum logic [2:0] {
    WAIT_SOF = 3'd0,
    V_PRE    = 3'd1,
    LINE     = 3'd2,
    H_BLK    = 3'd3,
    V_POST   = 3'd4,
    V_BLK    = 3'd5
  } dvp_state_t;

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame/line timing FSM with pixel, line and blanking counters.
module dvp_timing_gen
  import axis_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_PORCH  = 4,
  parameter int V_BLANK  = 8,
  localparam int PIX_W   = cnt_w(H_ACTIVE),
  localparam int LINE_W  = cnt_w(V_ACTIVE),
  localparam int BLK_W   = cnt_w(max3(H_BLANK, V_PORCH, V_BLANK))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  output logic [2:0]        state_o,
  output logic [PIX_W-1:0]  pix_o,
  output logic [LINE_W-1:0] line_o,
  output logic [BLK_W-1:0]  blk_o
);

  dvp_state_t        state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [BLK_W-1:0]  blk_q, blk_d;

  logic pix_last, line_last;

  assign pix_last  = (pix_q == PIX_W'(H_ACTIVE - 1));
  assign line_last = (line_q == LINE_W'(V_ACTIVE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_SOF;
      pix_q   <= '0;
      line_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_SOF: if (sof) state_d = V_PRE;
      V_PRE:    if (blk_q == BLK_W'(V_PORCH - 1)) state_d = LINE;
      LINE:     if (pix_last) state_d = line_last ? V_POST : H_BLK;
      H_BLK:    if (blk_q == BLK_W'(H_BLANK - 1)) state_d = LINE;
      V_POST:   if (blk_q == BLK_W'(V_PORCH - 1)) state_d = V_BLK;
      // A start-of-frame already waiting skips WAIT_SOF so back-to-back
      // frames are separated by exactly V_BLANK FV-low cycles.
      V_BLK:    if (blk_q == BLK_W'(V_BLANK - 1)) state_d = sof ? V_PRE : WAIT_SOF;
      default:  state_d = WAIT_SOF;
    endcase
  end

  always_comb begin
    pix_d  = '0;
    line_d = line_q;
    blk_d  = '0;
    case (state_q)
      LINE: begin
        if (!pix_last) pix_d = pix_q + 1'b1;
        else           line_d = line_last ? '0 : line_q + 1'b1;
      end
      V_PRE, H_BLK, V_POST, V_BLK: begin
        if (state_d == state_q) blk_d = blk_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state_q;
  assign pix_o   = pix_q;
  assign line_o  = line_q;
  assign blk_o   = blk_q;

endmodule

// File: rtl/axis_to_dvp.sv
// AXI-Stream video in, parallel DVP (FV/LV/D_OUT) out; fixed timing, never stalls the line.
module axis_to_dvp
  import axis_dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_PORCH  = 4,
  parameter int V_BLANK  = 8
) (
  input  logic                  pclk,
  input  logic                  reset,
  input  logic [DVP_DATA_W-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  FV,
  output logic                  LV,
  output logic [DVP_DATA_W-1:0] D_OUT,
  output logic                  frame_done,
  output logic                  err_underflow,
  output logic                  err_framing,
  output logic [2:0]            dbg_state
);

  // Handshake: a beat transfers on a pclk edge where tvalid and tready are both 1.
  // tready is 1 throughout LINE (the line never waits for data) and, in WAIT_SOF,
  // for every beat except the start-of-frame beat, which is held until LINE.

  localparam int PIX_W  = cnt_w(H_ACTIVE);
  localparam int LINE_W = cnt_w(V_ACTIVE);
  localparam int BLK_W  = cnt_w(max3(H_BLANK, V_PORCH, V_BLANK));

  logic [2:0]        state_raw;
  dvp_state_t        state;
  logic [PIX_W-1:0]  pix_idx;
  logic [LINE_W-1:0] line_idx;
  logic [BLK_W-1:0]  blk_idx;
  logic              sof;

  assign sof = s_axis_tvalid & s_axis_tuser;

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_PORCH  (V_PORCH),
    .V_BLANK  (V_BLANK)
  ) u_timing (
    .clk     (pclk),
    .rst     (reset),
    .sof     (sof),
    .state_o (state_raw),
    .pix_o   (pix_idx),
    .line_o  (line_idx),
    .blk_o   (blk_idx)
  );

  assign state     = dvp_state_t'(state_raw);
  assign dbg_state = state_raw;

  always_comb begin
    s_axis_tready = 1'b0;
    if (!reset) begin
      case (state)
        WAIT_SOF: s_axis_tready = !sof;
        LINE:     s_axis_tready = 1'b1;
        default:  s_axis_tready = 1'b0;
      endcase
    end
  end

  logic                  fv_q, fv_d;
  logic                  lv_q, lv_d;
  logic [DVP_DATA_W-1:0] dout_q, dout_d;
  logic                  frame_done_q, frame_done_d;
  logic                  err_u_q, err_u_d;
  logic                  err_f_q, err_f_d;
  logic                  in_line, beat_ok, first_pix, last_pix;

  assign in_line   = (state == LINE);
  assign beat_ok   = in_line && s_axis_tvalid;
  assign first_pix = (line_idx == '0) && (pix_idx == '0);
  assign last_pix  = (pix_idx == PIX_W'(H_ACTIVE - 1));

  // Outputs are the registered image of the current state, so the visible
  // FV/LV timeline trails the FSM by one cycle.
  always_comb begin
    fv_d         = (state == V_PRE) || (state == LINE) || (state == H_BLK) || (state == V_POST);
    lv_d         = in_line;
    dout_d       = beat_ok ? s_axis_tdata : '0;
    frame_done_d = (state == V_BLK) && (blk_idx == '0);
    err_u_d      = err_u_q || (in_line && !s_axis_tvalid);
    err_f_d      = err_f_q ||
                   (beat_ok && ((s_axis_tlast != last_pix) || (s_axis_tuser && !first_pix)));
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      fv_q         <= 1'b0;
      lv_q         <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
      err_u_q      <= 1'b0;
      err_f_q      <= 1'b0;
    end else begin
      fv_q         <= fv_d;
      lv_q         <= lv_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
      err_u_q      <= err_u_d;
      err_f_q      <= err_f_d;
    end
  end

  assign FV            = fv_q;
  assign LV            = lv_q;
  assign D_OUT         = dout_q;
  assign frame_done    = frame_done_q;
  assign err_underflow = err_u_q;
  assign err_framing   = err_f_q;

endmodule

// File: tb/tb_axis_to_dvp.sv
// Directed bench for axis_to_dvp with a small 4x2 frame geometry.
module tb_axis_to_dvp;
  import axis_dvp_pkg::*;

  localparam int HA = 4, VA = 2, HB = 2, VP = 1, VB = 3;
  localparam int FV_LEN = VP + HA * VA + HB * (VA - 1) + VP;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        FV, LV, frame_done, err_underflow, err_framing;
  logic [15:0] D_OUT;
  logic [2:0]  dbg_state;

  axis_to_dvp #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_PORCH(VP), .V_BLANK(VB)) dut (
    .pclk(pclk), .reset(reset), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .FV(FV), .LV(LV), .D_OUT(D_OUT), .frame_done(frame_done), .err_underflow(err_underflow),
    .err_framing(err_framing), .dbg_state(dbg_state)
  );

  always #5 pclk = ~pclk;

  typedef struct packed { logic v; logic u; logic l; logic [15:0] d; } beat_t;

  beat_t       src_q[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int          fv_runs[$], fv_gaps[$], lv_gaps[$];
  int          fd_cnt, d_bad, bad_acc, hi_len, lo_len, lvlo_len;
  logic        fv_prev, lv_prev, seen_frame, lv_seen, last_lv;
  logic [15:0] last_d;
  int          checks = 0, errors = 0;

  task automatic push_beat(input logic v, input logic u, input logic l, input logic [15:0] d);
    beat_t b;
    b.v = v; b.u = u; b.l = l; b.d = d;
    src_q.push_back(b);
  endtask

  task automatic push_frame(input logic [15:0] base);
    for (int l = 0; l < VA; l++)
      for (int p = 0; p < HA; p++)
        push_beat(1'b1, (l == 0 && p == 0), (p == HA - 1), base + 16'(l * HA + p));
  endtask

  task automatic clear_log();
    got_q.delete(); fv_runs.delete(); fv_gaps.delete(); lv_gaps.delete();
    fd_cnt = 0; d_bad = 0; bad_acc = 0; hi_len = 0; lo_len = 0; lvlo_len = 0;
    fv_prev = FV; lv_prev = LV; seen_frame = 1'b0; lv_seen = 1'b0;
  endtask

  task automatic record();
    dvp_state_t st;
    st = dvp_state_t'(dbg_state);
    if (FV && !fv_prev) begin
      if (seen_frame) fv_gaps.push_back(lo_len);
      hi_len = 0; lv_seen = 1'b0; lvlo_len = 0;
    end
    if (!FV && fv_prev) begin fv_runs.push_back(hi_len); seen_frame = 1'b1; lo_len = 0; end
    if (FV) hi_len++; else lo_len++;
    if (FV && !LV) lvlo_len++;
    if (LV && !lv_prev) begin
      if (lv_seen) lv_gaps.push_back(lvlo_len);
      lv_seen = 1'b1;
    end
    if (LV) begin lvlo_len = 0; got_q.push_back(D_OUT); end
    else if (D_OUT !== 16'h0) d_bad++;
    if (frame_done) fd_cnt++;
    if (s_axis_tvalid && s_axis_tready && !(st == LINE || (st == WAIT_SOF && !s_axis_tuser)))
      bad_acc++;
    fv_prev = FV; lv_prev = LV; last_lv = LV; last_d = D_OUT;
  endtask

  // One pclk cycle: present the head beat, sample at negedge, retire on accept.
  task automatic step();
    beat_t b;
    logic  acc;
    b = '0;
    if (src_q.size() > 0) b = src_q[0];
    s_axis_tvalid = b.v;
    s_axis_tdata  = b.v ? b.d : 16'h0;
    s_axis_tuser  = b.v & b.u;
    s_axis_tlast  = b.v & b.l;
    @(negedge pclk);
    record();
    acc = s_axis_tvalid && s_axis_tready;
    @(posedge pclk);
    if (src_q.size() > 0 && (!b.v || acc)) void'(src_q.pop_front());
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
  endtask

  task automatic apply_reset();
    src_q.delete();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge pclk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_axis_tvalid = 1'b1; s_axis_tuser = 1'b0; s_axis_tdata = 16'h1234;
    #12;
    checks++; if (FV !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", FV); end
    checks++; if (LV !== 1'b0) begin errors++; $display("FAIL reset_lv got %b exp 0", LV); end
    checks++; if (D_OUT !== 16'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", D_OUT); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b exp 0", s_axis_tready); end
    checks++; if ({frame_done, err_underflow, err_framing} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {frame_done, err_underflow, err_framing}); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(posedge pclk); #1 reset = 1'b0;
    #1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL wait_sof_drop_ready got %b exp 1", s_axis_tready); end
    s_axis_tuser = 1'b1;
    #1;
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL wait_sof_hold_ready got %b exp 0", s_axis_tready); end
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
  endtask

  task automatic test_basic();
    apply_reset(); clear_log();
    push_beat(1'b1, 1'b0, 1'b0, 16'h0001);
    push_beat(1'b1, 1'b0, 1'b0, 16'h0002);
    push_frame(16'h0010);
    run(40);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0010 + 16'(i));
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_pix%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fv_runs.size() != 1 || fv_runs[0] != FV_LEN) begin errors++; $display("FAIL basic_fv_len runs %0d got %0d exp %0d", fv_runs.size(), (fv_runs.size() > 0) ? fv_runs[0] : -1, FV_LEN); end
    checks++; if (lv_gaps.size() != 1 || lv_gaps[0] != HB) begin errors++; $display("FAIL basic_lv_gap n %0d got %0d exp %0d", lv_gaps.size(), (lv_gaps.size() > 0) ? lv_gaps[0] : -1, HB); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL basic_frame_done got %0d exp 1", fd_cnt); end
    checks++; if ({err_underflow, err_framing} !== 2'b00) begin errors++; $display("FAIL basic_errs got %b exp 00", {err_underflow, err_framing}); end
    checks++; if (d_bad != 0) begin errors++; $display("FAIL basic_dout_blank got %0d exp 0", d_bad); end
    checks++; if (bad_acc != 0) begin errors++; $display("FAIL basic_accept_blank got %0d exp 0", bad_acc); end
  endtask

  task automatic test_underflow();
    apply_reset(); clear_log();
    for (int p = 0; p < HA; p++) push_beat(1'b1, p == 0, p == HA - 1, 16'h0010 + 16'(p));
    push_beat(1'b1, 1'b0, 1'b0, 16'h0014);
    push_beat(1'b1, 1'b0, 1'b0, 16'h0015);
    push_beat(1'b0, 1'b0, 1'b0, 16'h0000);
    push_beat(1'b1, 1'b0, 1'b1, 16'h0017);
    run(40);
    exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0015, 16'h0000, 16'h0017};
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL under_len got %0d exp %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL under_pix%0d got %h exp %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL under_flag got %b exp 1", err_underflow); end
    checks++; if (err_framing !== 1'b0) begin errors++; $display("FAIL under_framing got %b exp 0", err_framing); end
    checks++; if (fv_runs.size() != 1 || fv_runs[0] != FV_LEN) begin errors++; $display("FAIL under_fv_len got %0d exp %0d", (fv_runs.size() > 0) ? fv_runs[0] : -1, FV_LEN); end
  endtask

  task automatic test_framing();
    apply_reset(); clear_log();
    push_beat(1'b1, 1'b1, 1'b0, 16'h0010);
    push_beat(1'b1, 1'b0, 1'b1, 16'h0011);
    push_beat(1'b1, 1'b0, 1'b0, 16'h0012);
    push_beat(1'b1, 1'b0, 1'b1, 16'h0013);
    for (int p = 0; p < HA; p++) push_beat(1'b1, 1'b0, p == HA - 1, 16'h0014 + 16'(p));
    run(40);
    checks++; if (err_framing !== 1'b1) begin errors++; $display("FAIL framing_flag got %b exp 1", err_framing); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL framing_under got %b exp 0", err_underflow); end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL framing_lv_count got %0d exp 8", got_q.size()); end
    checks++; if (lv_gaps.size() != 1 || lv_gaps[0] != HB) begin errors++; $display("FAIL framing_lv_gap got %0d exp %0d", (lv_gaps.size() > 0) ? lv_gaps[0] : -1, HB); end
    checks++; if (fv_runs.size() != 1 || fv_runs[0] != FV_LEN) begin errors++; $display("FAIL framing_fv_len got %0d exp %0d", (fv_runs.size() > 0) ? fv_runs[0] : -1, FV_LEN); end
  endtask

  task automatic test_reset_mid();
    logic found;
    apply_reset(); clear_log();
    push_frame(16'h0010);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (last_lv && last_d == 16'h0010) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach_pix2 got 0 exp 1"); end
    reset = 1'b1;
    #1;
    checks++; if (FV !== 1'b0) begin errors++; $display("FAIL midrst_fv got %b exp 0", FV); end
    checks++; if (LV !== 1'b0) begin errors++; $display("FAIL midrst_lv got %b exp 0", LV); end
    src_q.delete();
    s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
    @(posedge pclk); #1 reset = 1'b0;
    clear_log();
    push_beat(1'b1, 1'b0, 1'b0, 16'h0021);
    push_beat(1'b1, 1'b0, 1'b0, 16'h0022);
    push_beat(1'b1, 1'b0, 1'b1, 16'h0023);
    push_frame(16'h0030);
    run(40);
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL midrst_len got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== 16'h0030 + 16'(i)) begin errors++; $display("FAIL midrst_pix%0d got %h exp %h", i, got_q[i], 16'h0030 + 16'(i)); end
    end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL midrst_frame_done got %0d exp 1", fd_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset(); clear_log();
    push_frame(16'h0040);
    push_frame(16'h0050);
    run(60);
    checks++; if (fv_runs.size() != 2) begin errors++; $display("FAIL b2b_frames got %0d exp 2", fv_runs.size()); end
    for (int i = 0; i < fv_runs.size(); i++) begin
      checks++; if (fv_runs[i] != FV_LEN) begin errors++; $display("FAIL b2b_fv_len%0d got %0d exp %0d", i, fv_runs[i], FV_LEN); end
    end
    checks++; if (fv_gaps.size() != 1 || fv_gaps[0] != VB) begin errors++; $display("FAIL b2b_gap got %0d exp %0d", (fv_gaps.size() > 0) ? fv_gaps[0] : -1, VB); end
    checks++; if (fd_cnt != 2) begin errors++; $display("FAIL b2b_frame_done got %0d exp 2", fd_cnt); end
    checks++; if (got_q.size() != 16 || got_q[8] !== 16'h0050) begin errors++; $display("FAIL b2b_data n %0d second %h exp 16/0050", got_q.size(), (got_q.size() > 8) ? got_q[8] : 16'hffff); end
    checks++; if ({err_underflow, err_framing} !== 2'b00) begin errors++; $display("FAIL b2b_errs got %b exp 00", {err_underflow, err_framing}); end
  endtask

  task automatic test_random_valid();
    apply_reset(); clear_log();
    for (int l = 0; l < VA; l++)
      for (int p = 0; p < HA; p++) begin
        repeat ($urandom_range(0, 2)) push_beat(1'b0, 1'b0, 1'b0, 16'h0000);
        push_beat(1'b1, (l == 0 && p == 0), (p == HA - 1), 16'h0060 + 16'(l * HA + p));
      end
    run(60);
    checks++; if (bad_acc != 0) begin errors++; $display("FAIL rand_accept_blank got %0d exp 0", bad_acc); end
    checks++; if (fv_runs.size() != 1 || fv_runs[0] != FV_LEN) begin errors++; $display("FAIL rand_fv_len got %0d exp %0d", (fv_runs.size() > 0) ? fv_runs[0] : -1, FV_LEN); end
    checks++; if (got_q.size() != HA * VA) begin errors++; $display("FAIL rand_lv_count got %0d exp %0d", got_q.size(), HA * VA); end
    checks++; if (d_bad != 0) begin errors++; $display("FAIL rand_dout_blank got %0d exp 0", d_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_framing();
    test_reset_mid();
    test_back_to_back();
    test_random_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
